// File: rtl/z80plus_pkg.sv
// Shared definitions for the Z80 bus window: FSM state encoding and the
// default Z80-phase timing.
package z80plus_pkg;

   typedef enum logic [1:0] {
      ST_VIC   = 2'd0,
      ST_OPEN  = 2'd1,
      ST_GUARD = 2'd2,
      ST_STALL = 2'd3
   } win_state_e;

   localparam int unsigned LOWLEN_DEF = 4;
   localparam int unsigned GUARD_DEF  = 1;
   localparam logic [2:0]  PHASE_MAX  = 3'd7;

endpackage

// File: rtl/z80_bus_window_if.sv
// Bus-side signals of the Z80 bus window: phase clock and Z80 strobes in,
// clock-enable / wait request and debug status out.
interface z80_bus_window_if;

   logic       clk1mhz;
   logic       nmreq;
   logic       niorq;
   logic       nrfsh;
   logic       clocksel;
   logic       clken;
   logic       nwaitreq;
   logic [2:0] phase;
   logic [1:0] state;

   modport master (
      output clk1mhz, nmreq, niorq, nrfsh, clocksel,
      input  clken, nwaitreq, phase, state
   );

   modport slave (
      input  clk1mhz, nmreq, niorq, nrfsh, clocksel,
      output clken, nwaitreq, phase, state
   );

endinterface

// File: rtl/z80plus_sync.sv
// Multi-flop synchronizer for asynchronous level inputs, with configurable
// depth, width and per-bit reset value.
module z80plus_sync #(
   parameter int unsigned      STAGES  = 2,
   parameter int unsigned      WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [STAGES];

   // NOTE: this array is a flop chain, not a RAM, so every stage is reset;
   // a memory would normally be left unreset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < STAGES; i++) stage[i] <= RST_VAL;
      end else begin
         stage[0] <= d;
         for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/z80_bus_window.sv
// Z80 access window inside the CLK1MHZ low phase: gates the fast Z80 clock
// and stretches accesses that overrun into the video half with /WAIT.
module z80_bus_window
   import z80plus_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned LOWLEN      = LOWLEN_DEF,
   parameter int unsigned GUARD       = GUARD_DEF
) (
   input logic             clkdot,
   input logic             nreset,
   z80_bus_window_if.slave bus
);

   localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);
   localparam logic [2:0] GUARD_AT  = 3'(LOWLEN - GUARD - 1);

   logic       act_raw;
   logic       clk1_s;
   logic       clk1_prev;
   logic [1:0] ctl_s;
   logic       csel_s;
   logic       act_s;
   logic [2:0] warm;
   logic       fall;
   logic       rise;
   logic [2:0] phase_q;
   logic [2:0] phase_d;
   win_state_e state_q;
   win_state_e state_d;
   logic       clken_q;
   logic       clken_d;
   logic       nwait_q;
   logic       nwait_d;

   assign act_raw = bus.nrfsh & (~bus.nmreq | ~bus.niorq);

   z80plus_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1)) u_clk_sync (
      .clk   (clkdot),
      .rst_n (nreset),
      .d     (bus.clk1mhz),
      .q     (clk1_s)
   );

   z80plus_sync #(.STAGES(SYNC_STAGES), .WIDTH(2), .RST_VAL(2'b00)) u_ctl_sync (
      .clk   (clkdot),
      .rst_n (nreset),
      .d     ({bus.clocksel, act_raw}),
      .q     (ctl_s)
   );

   assign {csel_s, act_s} = ctl_s;

   // Falls are ignored until the synchronizer and history flop hold real
   // samples, so a CLK1MHZ already low at reset release is not an edge.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clkdot or negedge nreset) begin
      if (!nreset) begin
         clk1_prev <= 1'b1;
         warm      <= '0;
      end else begin
         clk1_prev <= clk1_s;
         if (warm != WARM_DONE) warm <= warm + 3'd1;
      end
   end

   assign fall = (warm == WARM_DONE) & clk1_prev & ~clk1_s;
   assign rise = ~clk1_prev & clk1_s;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      phase_d = phase_q;
      if (fall)                    phase_d = '0;
      else if (phase_q != PHASE_MAX) phase_d = phase_q + 3'd1;
   end

   // The guard test uses the next PHASE so STATE enters GUARD in the same
   // cycle PHASE shows LOWLEN-GUARD-1.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_VIC:   if (fall) state_d = ST_OPEN;
         ST_OPEN: begin
            if (rise)                                 state_d = act_s ? ST_STALL : ST_VIC;
            else if (phase_d == GUARD_AT && !act_s)   state_d = ST_GUARD;
         end
         ST_GUARD: begin
            if (act_s)     state_d = ST_STALL;
            else if (rise) state_d = ST_VIC;
         end
         ST_STALL: if (fall) state_d = ST_OPEN;
         default:  state_d = ST_VIC;
      endcase
      if (!csel_s) state_d = ST_VIC;
      clken_d = (state_d == ST_OPEN);
      nwait_d = (state_d != ST_STALL);
   end

   always_ff @(posedge clkdot or negedge nreset) begin
      if (!nreset) begin
         state_q <= ST_VIC;
         phase_q <= '0;
         clken_q <= 1'b0;
         nwait_q <= 1'b1;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         clken_q <= clken_d;
         nwait_q <= nwait_d;
      end
   end

   assign bus.clken    = clken_q;
   assign bus.nwaitreq = nwait_q;
   assign bus.phase    = phase_q;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_z80_bus_window.sv
// Directed bench for z80_bus_window: 8-dot CLK1MHZ periods with scripted
// access strobes, compared against hand-derived per-dot expectations.
module tb_z80_bus_window;

   logic clkdot = 1'b0;
   logic nreset;
   int   total = 0;
   int   bad   = 0;
   int   act_mode;   // 0: memory access, 1: I/O access, 2: refresh cycle
   int   nwait_lows;
   int   non_vic;

   z80_bus_window_if bus ();

   z80_bus_window #(.SYNC_STAGES(2), .LOWLEN(4), .GUARD(1)) dut (
      .clkdot (clkdot),
      .nreset (nreset),
      .bus    (bus)
   );

   always #5 clkdot = ~clkdot;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int st_code(input byte c);
      case (c)
         "V":     return 0;
         "O":     return 1;
         "G":     return 2;
         "S":     return 3;
         default: return -1;
      endcase
   endfunction

   // Drive one dot of inputs after a falling edge, then wait for the next
   // falling edge so outputs are sampled mid-cycle.
   task automatic tick(input logic c1, input logic a, input logic cs);
      bus.clk1mhz  = c1;
      bus.clocksel = cs;
      bus.nmreq    = 1'b1;
      bus.niorq    = 1'b1;
      bus.nrfsh    = 1'b1;
      if (a) begin
         case (act_mode)
            0:       bus.nmreq = 1'b0;
            1:       bus.niorq = 1'b0;
            default: begin
               bus.nmreq = 1'b0;
               bus.nrfsh = 1'b0;
            end
         endcase
      end
      @(negedge clkdot);
   endtask

   // One CLK1MHZ period: low for dots 0..3, high for 4..7. Bit i of the
   // masks and character i of the strings belong to dot i.
   task automatic run_period(input string name, input logic [7:0] act_bits,
                             input logic [7:0] cs_bits, input string st,
                             input string ck, input string nw, input bit chk_ph);
      for (int i = 0; i < 8; i++) begin
         tick(i >= 4, act_bits[i], cs_bits[i]);
         check($sformatf("%s[%0d].state", name, i), int'(bus.state), st_code(st[i]));
         check($sformatf("%s[%0d].clken", name, i), int'(bus.clken), (ck[i] == "1") ? 1 : 0);
         check($sformatf("%s[%0d].nwaitreq", name, i), int'(bus.nwaitreq), (nw[i] == "1") ? 1 : 0);
         if (chk_ph) check($sformatf("%s[%0d].phase", name, i), int'(bus.phase), (i + 6) % 8);
      end
   endtask

   initial begin
      nreset       = 1'b0;
      act_mode     = 0;
      bus.clk1mhz  = 1'b1;
      bus.clocksel = 1'b1;
      bus.nmreq    = 1'b1;
      bus.niorq    = 1'b1;
      bus.nrfsh    = 1'b1;
      repeat (3) @(negedge clkdot);
      check("rst.state", int'(bus.state), 0);
      check("rst.clken", int'(bus.clken), 0);
      check("rst.nwaitreq", int'(bus.nwaitreq), 1);
      check("rst.phase", int'(bus.phase), 0);
      nreset = 1'b1;
      repeat (4) tick(1'b1, 1'b0, 1'b1);

      run_period("warm", 8'h00, 8'hFF, "VVOOGGVV", "00110000", "11111111", 1'b0);
      run_period("idle1", 8'h00, 8'hFF, "VVOOGGVV", "00110000", "11111111", 1'b1);
      run_period("idle2", 8'h00, 8'hFF, "VVOOGGVV", "00110000", "11111111", 1'b1);

      run_period("short_acc", 8'b0000_0110, 8'hFF, "VVOOOOVV", "00111100", "11111111", 1'b1);
      run_period("after_short", 8'h00, 8'hFF, "VVOOGGVV", "00110000", "11111111", 1'b1);

      run_period("stall", 8'b0001_1100, 8'hFF, "VVOOOOSS", "00111100", "11111100", 1'b1);
      run_period("stall_exit", 8'h00, 8'hFF, "SSOOGGVV", "00110000", "00111111", 1'b1);

      act_mode = 1;
      run_period("io_drop_at_rise", 8'b0000_1100, 8'hFF, "VVOOOOVV", "00111100", "11111111", 1'b1);
      run_period("after_io", 8'h00, 8'hFF, "VVOOGGVV", "00110000", "11111111", 1'b1);

      act_mode = 2;
      run_period("refresh", 8'b0001_1100, 8'hFF, "VVOOGGVV", "00110000", "11111111", 1'b1);
      act_mode = 0;

      run_period("guard_acc", 8'b0000_1000, 8'hFF, "VVOOGSSS", "00110000", "11111000", 1'b1);
      run_period("guard_exit", 8'h00, 8'hFF, "SSOOGGVV", "00110000", "00111111", 1'b1);

      run_period("csel_stall", 8'b0001_1100, 8'b0011_1111, "VVOOOOSS", "00111100", "11111100", 1'b1);
      run_period("csel_off", 8'h00, 8'h00, "VVVVVVVV", "00000000", "11111111", 1'b1);
      run_period("csel_on", 8'h00, 8'hFF, "VVOOGGVV", "00110000", "11111111", 1'b1);

      // Reset pulse landing between dot edges while the Z80 is held.
      run_period("pre_reset", 8'b0001_1100, 8'hFF, "VVOOOOSS", "00111100", "11111100", 1'b1);
      #2 nreset = 1'b0;
      #1;
      check("async_rst.nwaitreq", int'(bus.nwaitreq), 1);
      check("async_rst.state", int'(bus.state), 0);
      check("async_rst.clken", int'(bus.clken), 0);
      check("async_rst.phase", int'(bus.phase), 0);

      // Release with CLK1MHZ already low: no window may open.
      bus.clk1mhz = 1'b0;
      repeat (2) @(negedge clkdot);
      nreset     = 1'b1;
      nwait_lows = 0;
      non_vic    = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 1'b0, 1'b1);
         if (bus.nwaitreq == 1'b0) nwait_lows++;
         if (bus.state != 2'd0)    non_vic++;
      end
      check("low_release.non_vic_dots", non_vic, 0);
      check("low_release.wait_dots", nwait_lows, 0);
      check("low_release.phase", int'(bus.phase), 7);

      // CLK1MHZ stuck low after a genuine fall.
      repeat (4) tick(1'b1, 1'b0, 1'b1);
      nwait_lows = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 1'b0, 1'b1);
         if (bus.nwaitreq == 1'b0) nwait_lows++;
         if (i == 2) check("stuck.open_state", int'(bus.state), 1);
         if (i == 4) check("stuck.guard_state", int'(bus.state), 2);
      end
      check("stuck.final_state", int'(bus.state), 2);
      check("stuck.phase", int'(bus.phase), 7);
      check("stuck.wait_dots", nwait_lows, 0);
      check("stuck.clken", int'(bus.clken), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
